pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_PULSE_CYC, default 16: length of the PLL reset pulse, in clk cycles.
REQ-002 Parameter LOCK_WAIT_CYC, default 50000: lock timeout, 1 ms at 50 MHz.
REQ-003 Parameter STABLE_CYC, default 1024: number of consecutive locked cycles required before downstream release.
REQ-004 Parameter MAX_RETRY, default 4: number of consecutive timeouts before FAIL.
REQ-005 One clock, clk; reset is synchronous and active-low, rst_n.
REQ-006 Ports:
- clk  in  1  free-running 50 MHz reference, the same source as the PLL input.
- rst_n  in  1  synchronous active-low reset.
- pll_lock  in  1  PLL lock flag, asynchronous to clk.
- retry_req  in  1  single-cycle request to leave FAIL.
- pll_rst  out  1  drives the PLL RST input, active-high.
- video_rst_n  out  1  active-low reset for the video-out domain logic.
- lock_stable  out  1  high while in RUN.
- fail  out  1  high while in FAIL.
- relock_cnt  out  8  count of lock losses seen in RUN, saturating.

Function
REQ-007 pll_lock SHALL pass through a 2-flop synchroniser; lock_s is the second flop, and all decisions use lock_s only.
REQ-008 States SHALL be RESET_PLL, WAIT_LOCK, STABLE_CHK, RUN, FAIL; outputs are decoded directly from the registered state (Moore, no added latency).
REQ-009 RESET_PLL: pll_rst=1; a single shared timer counts; after exactly RST_PULSE_CYC cycles in the state the FSM moves to WAIT_LOCK with the timer cleared.
REQ-010 WAIT_LOCK: pll_rst=0; if lock_s=1 go to STABLE_CHK with the timer cleared.
REQ-011 WAIT_LOCK timeout: if the timer reaches LOCK_WAIT_CYC-1 with lock_s=0, retry_cnt increments; go to FAIL if the new value equals MAX_RETRY, else go to RESET_PLL.
REQ-012 WAIT_LOCK tie-break: lock_s=1 on the timeout cycle wins, and the FSM goes to STABLE_CHK.
REQ-013 STABLE_CHK: the timer counts while lock_s=1.
- After STABLE_CYC consecutive cycles go to RUN and clear retry_cnt.
- Any lock_s=0 returns to WAIT_LOCK with the timer cleared; retry_cnt is unchanged.
REQ-014 RUN: video_rst_n=1 and lock_stable=1.
- lock_s=0 goes to RESET_PLL.
- relock_cnt increments, saturating at 255.
REQ-015 FAIL: pll_rst=0, fail=1, video_rst_n=0; retry_req=1 goes to RESET_PLL and clears retry_cnt.
REQ-016 retry_req SHALL be ignored in every state except FAIL.
REQ-017 video_rst_n SHALL be 0 in every state except RUN; it deasserts in the same cycle the state enters RUN.
REQ-018 Timer width SHALL be $clog2 of the largest of the three cycle parameters; retry_cnt width is $clog2(MAX_RETRY+1).
REQ-019 pll_rst SHALL never glitch: it is a registered output or a pure decode of the one-hot state register.

Reset
REQ-020 rst_n=0 at a clk edge SHALL set:
- state to RESET_PLL, with timer and retry_cnt at 0;
- both sync flops to 0;
- pll_rst=1, video_rst_n=0, lock_stable=0, fail=0, relock_cnt=0.
REQ-021 Reset asserted in any state, including mid-pulse or mid-STABLE_CHK, SHALL restart the sequence from REQ-020 on the next edge.
REQ-022 relock_cnt SHALL clear only on rst_n.

Structure
REQ-023 Package pll_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-024 The synchroniser SHALL be the sub-module sync_2ff (1-bit, same clk, same synchronous active-low reset); the FSM, timer and counters stay in pll_lock_sequencer.
REQ-025 pll_lock_sequencer SHALL contain no PLL instance; the top level wires pll_rst and pll_lock to the PLL wrapper.

Verification (bench parameters RST_PULSE_CYC=4, LOCK_WAIT_CYC=20, STABLE_CYC=8, MAX_RETRY=2)
REQ-026 Clean lock: release rst_n, then raise pll_lock 10 cycles later and hold it.
- Required: pll_rst high for exactly 4 cycles.
- Required: video_rst_n rises 2+8 cycles after pll_lock rises, within 1 cycle.
- Required: relock_cnt=0.
REQ-027 Timeout to FAIL: hold pll_lock=0.
- Required: two pll_rst pulses of 4 cycles, each followed by 20 WAIT_LOCK cycles.
- Required: fail=1 after the second timeout, with pll_rst=0 held thereafter.
REQ-028 Chatter: in STABLE_CHK, drop pll_lock for 1 cycle at stable-count 5.
- Required: video_rst_n stays 0 and no pll_rst pulse occurs.
- Required: once lock is steady again, release occurs 8 cycles after re-lock; retry_cnt is unchanged.
REQ-029 Lock loss in RUN: drop pll_lock for 3 cycles.
- Required: 2 cycles later video_rst_n=0 and pll_rst=1 for 4 cycles.
- Required: relock_cnt=1.
- Required: after 256 such losses, relock_cnt=255.
REQ-030 FAIL recovery: pulse retry_req in RUN and observe no effect; pulse it in FAIL and see pll_rst=1 on the next cycle, then a normal lock.
REQ-031 Reset mid-operation: assert rst_n=0 for 1 cycle in STABLE_CHK and in RUN; every output matches REQ-020 on the next edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
// State is one-hot so every output is a single flop bit.
package pll_seq_pkg;

  localparam int DEF_RST_PULSE_CYC = 16;
  localparam int DEF_LOCK_WAIT_CYC = 50000;
  localparam int DEF_STABLE_CYC    = 1024;
  localparam int DEF_MAX_RETRY     = 4;

  localparam int IDX_RESET_PLL  = 0;
  localparam int IDX_WAIT_LOCK  = 1;
  localparam int IDX_STABLE_CHK = 2;
  localparam int IDX_RUN        = 3;
  localparam int IDX_FAIL       = 4;

  typedef enum logic [4:0] {
    S_RESET_PLL  = 5'b00001,
    S_WAIT_LOCK  = 5'b00010,
    S_STABLE_CHK = 5'b00100,
    S_RUN        = 5'b01000,
    S_FAIL       = 5'b10000
  } state_e;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, rst_n (sync, active-low), d_i async in, q_o synced out.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for a stable lock,
// then releases the video domain. Ports: clk, rst_n, pll_lock, retry_req
// in; pll_rst, video_rst_n, lock_stable, fail, relock_cnt[7:0] out.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC = DEF_RST_PULSE_CYC,
  parameter int LOCK_WAIT_CYC = DEF_LOCK_WAIT_CYC,
  parameter int STABLE_CYC    = DEF_STABLE_CYC,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       lock_stable,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam int TMAX = max3(RST_PULSE_CYC, LOCK_WAIT_CYC, STABLE_CYC);
  localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
  localparam int RW   = ($clog2(MAX_RETRY + 1) < 1) ? 1
                        : $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] RP_LAST = TW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0] LW_LAST = TW'(LOCK_WAIT_CYC - 1);
  localparam logic [TW-1:0] SC_LAST = TW'(STABLE_CYC - 1);
  localparam logic [RW-1:0] RT_MAX  = RW'(MAX_RETRY);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [7:0]      relock_q, relock_d;
  logic [RW-1:0]   retry_inc;
  logic            lock_s;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  assign retry_inc = retry_q + RW'(1);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    unique case (state_q)
      S_RESET_PLL: begin
        if (timer_q == RP_LAST) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_LOCK: begin
        // lock wins over a coincident timeout
        if (lock_s) begin
          state_d = S_STABLE_CHK;
          timer_d = '0;
        end else if (timer_q == LW_LAST) begin
          retry_d = retry_inc;
          timer_d = '0;
          state_d = (retry_inc == RT_MAX) ? S_FAIL : S_RESET_PLL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_STABLE_CHK: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == SC_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
          retry_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_RESET_PLL;
          timer_d = '0;
          if (relock_q != 8'hFF) begin
            relock_d = relock_q + 8'd1;
          end
        end
      end
      S_FAIL: begin
        if (retry_req) begin
          state_d = S_RESET_PLL;
          timer_d = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_RESET_PLL;
      timer_q  <= '0;
      retry_q  <= '0;
      relock_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      relock_q <= relock_d;
    end
  end

  assign pll_rst     = state_q[IDX_RESET_PLL];
  assign video_rst_n = state_q[IDX_RUN];
  assign lock_stable = state_q[IDX_RUN];
  assign fail        = state_q[IDX_FAIL];
  assign relock_cnt  = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios with
// literal expectations plus randomized traffic against a cycle model.
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int LW = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       retry_req = 1'b0;
  logic       pll_rst;
  logic       video_rst_n;
  logic       lock_stable;
  logic       fail;
  logic [7:0] relock_cnt;

  int checks = 0;
  int failures = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYC (RP),
    .LOCK_WAIT_CYC (LW),
    .STABLE_CYC    (SC),
    .MAX_RETRY     (MR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .retry_req   (retry_req),
    .pll_rst     (pll_rst),
    .video_rst_n (video_rst_n),
    .lock_stable (lock_stable),
    .fail        (fail),
    .relock_cnt  (relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: phase + cycles completed in that phase.
  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

  int ph = P_RST;
  int n = 0;
  int tries = 0;
  int relocks = 0;
  bit lk[2] = '{1'b0, 1'b0};
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    bit ls;
    if (!rst_n) begin
      ph = P_RST; n = 0; tries = 0; relocks = 0;
      lk[0] = 1'b0; lk[1] = 1'b0;
      m_valid = 1'b1;
    end else begin
      ls = lk[1];
      case (ph)
        P_RST: begin
          n++;
          if (n == RP) begin ph = P_WAIT; n = 0; end
        end
        P_WAIT: begin
          n++;
          if (ls) begin
            ph = P_STAB; n = 0;
          end else if (n == LW) begin
            tries++;
            n = 0;
            ph = (tries == MR) ? P_FAIL : P_RST;
          end
        end
        P_STAB: begin
          if (!ls) begin
            ph = P_WAIT; n = 0;
          end else begin
            n++;
            if (n == SC) begin ph = P_RUN; n = 0; tries = 0; end
          end
        end
        P_RUN: begin
          if (!ls) begin
            ph = P_RST; n = 0;
            relocks = (relocks < 255) ? relocks + 1 : 255;
          end
        end
        default: begin
          if (retry_req) begin ph = P_RST; n = 0; tries = 0; end
        end
      endcase
      lk[1] = lk[0];
      lk[0] = pll_lock;
    end
    #1;
    if (m_valid) begin
      chk("m_pll_rst", int'(pll_rst), int'(ph == P_RST));
      chk("m_video_rst_n", int'(video_rst_n), int'(ph == P_RUN));
      chk("m_lock_stable", int'(lock_stable), int'(ph == P_RUN));
      chk("m_fail", int'(fail), int'(ph == P_FAIL));
      chk("m_relock_cnt", int'(relock_cnt), relocks);
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset(input bit lkv);
    @(negedge clk);
    rst_n = 1'b0;
    pll_lock = lkv;
    retry_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_video(input int bound);
    int c;
    c = 0;
    while (!video_rst_n && c < bound) begin
      @(negedge clk);
      c++;
    end
    if (!video_rst_n) chk("video_release_timeout", 0, 1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_pll_rst"}, int'(pll_rst), 1);
    chk({nm, "_video_rst_n"}, int'(video_rst_n), 0);
    chk({nm, "_lock_stable"}, int'(lock_stable), 0);
    chk({nm, "_fail"}, int'(fail), 0);
    chk({nm, "_relock"}, int'(relock_cnt), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, rise, pr, idx, rate, pulses, fail_at, rst_in_fail;
    bit prev;

    step(3);
    chk_reset_outs("reset");

    // clean lock
    do_reset(1'b0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (pll_rst) hi++;
      @(negedge clk);
    end
    chk("clean_rst_pulse_len", hi, 4);
    pll_lock = 1'b1;
    rise = 0;
    while (!video_rst_n && rise < 40) begin
      @(negedge clk);
      rise++;
    end
    chk("clean_release_10or11", int'(rise >= 10 && rise <= 11), 1);
    chk("clean_relock", int'(relock_cnt), 0);

    // chatter at stable-count 5
    do_reset(1'b1);
    step(8);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    pr = 0;
    rise = -1;
    for (int i = 9; i <= 40; i++) begin
      if (pll_rst) pr++;
      if (video_rst_n && rise < 0) rise = i;
      @(negedge clk);
    end
    chk("chatter_no_pll_rst", pr, 0);
    chk("chatter_release_at", rise, 20);

    // lock loss in RUN
    pll_lock = 1'b0;
    pr = 0;
    idx = -1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) pll_lock = 1'b1;
      if (pll_rst) pr++;
      if (pll_rst && !video_rst_n && idx < 0) idx = i;
      @(negedge clk);
    end
    chk("loss_rst_pulse_len", pr, 4);
    chk("loss_react_2to3", int'(idx >= 2 && idx <= 3), 1);
    wait_video(60);
    chk("loss_relock_1", int'(relock_cnt), 1);

    // retry_req ignored in RUN
    retry_req = 1'b1;
    @(negedge clk);
    retry_req = 1'b0;
    chk("run_retry_stable", int'(lock_stable), 1);
    chk("run_retry_no_rst", int'(pll_rst), 0);

    // saturation
    for (int k = 0; k < 256; k++) begin
      pll_lock = 1'b0;
      step(3);
      pll_lock = 1'b1;
      wait_video(60);
    end
    chk("relock_saturated", int'(relock_cnt), 255);

    // timeout to FAIL
    do_reset(1'b0);
    pulses = 0;
    hi = 0;
    fail_at = -1;
    rst_in_fail = 0;
    prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (pll_rst) hi++;
      if (pll_rst && !prev) pulses++;
      prev = pll_rst;
      if (fail && fail_at < 0) fail_at = i;
      if (fail && pll_rst) rst_in_fail++;
      @(negedge clk);
    end
    chk("timeout_pulses", pulses, 2);
    chk("timeout_rst_cycles", hi, 8);
    chk("timeout_fail_at", fail_at, 48);
    chk("timeout_rst_in_fail", rst_in_fail, 0);
    chk("timeout_fail_held", int'(fail), 1);

    // FAIL recovery
    retry_req = 1'b1;
    @(negedge clk);
    retry_req = 1'b0;
    chk("recover_pll_rst", int'(pll_rst), 1);
    chk("recover_fail_low", int'(fail), 0);
    pll_lock = 1'b1;
    wait_video(60);
    chk("recover_run", int'(lock_stable), 1);

    // reset mid STABLE_CHK and mid RUN
    do_reset(1'b1);
    step(6);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs("midstab");
    rst_n = 1'b1;
    wait_video(60);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs("midrun");
    rst_n = 1'b1;

    // randomized traffic, model-checked every cycle
    for (int s = 0; s < 20; s++) begin
      case ($urandom_range(2))
        0: rate = 4;
        1: rate = 30;
        default: rate = 100;
      endcase
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if ($urandom_range(rate - 1) == 0) pll_lock = ~pll_lock;
        retry_req = ($urandom_range(15) == 0);
        rst_n = ($urandom_range(299) != 0);
      end
    end
    retry_req = 1'b0;
    rst_n = 1'b1;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
